// File: rtl/riscv_uart_tx.sv
// rtl/riscv_uart_tx.sv - memory-stage UART transmitter with TX FIFO and 8N1 serialiser
//
// Ports:
//   i_riscv_uart_clk       core clock, all state updates on the rising edge
//   i_riscv_uart_rst       synchronous active-high reset
//   i_riscv_uart_tx_valid  memory-stage UART store strobe
//   i_riscv_uart_tx_data   byte to send
//   o_riscv_uart_stall     store presented while FIFO full; holds the pipeline
//   o_riscv_uart_tx        serial line, idle high, registered
//   o_riscv_uart_busy      frame FSM not in IDLE
//   o_riscv_uart_empty     FIFO holds no entries
//   o_riscv_uart_full      FIFO holds FIFO_DEPTH entries
//   o_riscv_uart_count     FIFO occupancy
module riscv_uart_tx #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            i_riscv_uart_clk,
    input  logic                            i_riscv_uart_rst,
    input  logic                            i_riscv_uart_tx_valid,
    input  logic [7:0]                      i_riscv_uart_tx_data,
    output logic                            o_riscv_uart_stall,
    output logic                            o_riscv_uart_tx,
    output logic                            o_riscv_uart_busy,
    output logic                            o_riscv_uart_empty,
    output logic                            o_riscv_uart_full,
    output logic [$clog2(FIFO_DEPTH):0]     o_riscv_uart_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      mem [FIFO_DEPTH];

    logic            full;
    logic            push;
    logic            pop;
    logic            baud_done;

    // Full is taken from the pre-edge count, so a pop on the same edge
    // never frees room for the store being presented.
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign push      = i_riscv_uart_tx_valid && !full;
    assign baud_done = (baud_q == BW'(BAUD_DIV - 1));

    // State register
    always_ff @(posedge i_riscv_uart_clk) begin
        if (i_riscv_uart_rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge i_riscv_uart_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_riscv_uart_tx_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: tx is computed from the next state and registered,
    // so the line changes only on clock edges.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign o_riscv_uart_tx    = tx_q;
    assign o_riscv_uart_busy  = (state_q != S_IDLE);
    assign o_riscv_uart_empty = (count_q == '0);
    assign o_riscv_uart_full  = full;
    assign o_riscv_uart_count = count_q;
    assign o_riscv_uart_stall = i_riscv_uart_tx_valid && full;

endmodule

// File: tb/tb_riscv_uart_tx.sv
// tb/tb_riscv_uart_tx.sv - directed self-checking bench for riscv_uart_tx
module tb_riscv_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       stall, tx, busy, empty, full;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q [$];
    int         frame_err = 0;

    always #5 clk = ~clk;

    riscv_uart_tx #(.BAUD_DIV(4), .FIFO_DEPTH(8)) dut (
        .i_riscv_uart_clk      (clk),
        .i_riscv_uart_rst      (rst),
        .i_riscv_uart_tx_valid (valid),
        .i_riscv_uart_tx_data  (data),
        .o_riscv_uart_stall    (stall),
        .o_riscv_uart_tx       (tx),
        .o_riscv_uart_busy     (busy),
        .o_riscv_uart_empty    (empty),
        .o_riscv_uart_full     (full),
        .o_riscv_uart_count    (count)
    );

    // Serial receiver: samples each bit in mid-period (BAUD_DIV=4, offset 2).
    // Frames overlapping a reset are dropped.
    initial begin
        logic [7:0] rb;
        bit         bad, start_ok, stop_ok;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                bad = 1'b0; start_ok = 1'b0; stop_ok = 1'b0; rb = 8'h00;
                for (int c = 1; c <= 39; c++) begin
                    @(negedge clk);
                    if (rst) bad = 1'b1;
                    if (c == 2) start_ok = (tx === 1'b0);
                    if (c >= 6 && c <= 34 && (c % 4) == 2) rb[(c - 6) / 4] = tx;
                    if (c == 38) stop_ok = (tx === 1'b1);
                end
                if (!bad) begin
                    if (start_ok && stop_ok) rx_q.push_back(rb);
                    else frame_err++;
                end
            end
        end
    end

    task automatic wait_idle(input int budget, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (busy || !empty) begin
            @(negedge clk);
            n++;
            if (n >= budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle: tx=%b busy=%b want 1/0", tx, busy); end
    endtask

    task automatic test_single_frame;
        logic [9:0] f;
        bit         to;
        f = {1'b1, 8'hA5, 1'b0};
        rx_q.delete(); frame_err = 0;
        @(negedge clk);
        valid = 1'b1; data = 8'hA5;
        @(negedge clk);
        valid = 1'b0; data = 8'h3C;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL t1_tx_after_push: got %b want 1", tx); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL t1_count_after_push: got %0d want 1", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after_push: got %b want 0", busy); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++; if (tx !== f[c / 4]) begin errors++; $display("FAIL t1_tx_cycle%0d: got %b want %b", c, tx, f[c / 4]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_cycle%0d: got %b want 1", c, busy); end
        end
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL t1_tx_end: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_end: got %b want 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t1_empty_end: got %b want 1", empty); end
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL t1_idle_timeout: got timeout want idle"); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL t1_rx: got size %0d want 1 byte A5", rx_q.size()); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] f0, f1;
        logic       e;
        int         max_cnt;
        bit         to;
        f0 = {1'b1, 8'h00, 1'b0};
        f1 = {1'b1, 8'hFF, 1'b0};
        rx_q.delete(); frame_err = 0;
        @(negedge clk);
        valid = 1'b1; data = 8'h00;
        @(negedge clk);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL t2_count_first: got %0d want 1", count); end
        data = 8'hFF;
        @(negedge clk);
        valid = 1'b0;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL t2_count_push_pop: got %0d want 1", count); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL t2_first_start: got %b want 0", tx); end
        max_cnt = 0;
        for (int c = 1; c < 80; c++) begin
            @(negedge clk);
            e = (c < 40) ? f0[c / 4] : f1[(c - 40) / 4];
            if (int'(count) > max_cnt) max_cnt = int'(count);
            checks++; if (tx !== e) begin errors++; $display("FAIL t2_tx_cycle%0d: got %b want %b", c, tx, e); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t2_busy_cycle%0d: got %b want 1", c, busy); end
        end
        checks++; if (max_cnt != 1) begin errors++; $display("FAIL t2_count_peak: got %0d want 1", max_cnt); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL t2_end_idle: busy=%b tx=%b want 0/1", busy, tx); end
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL t2_idle_timeout: got timeout want idle"); end
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL t2_rx_size: got %0d want 2", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin errors++; $display("FAIL t2_rx_data: got %h %h want 00 ff", rx_q[0], rx_q[1]); end
        end
    endtask

    // Also covers the full-FIFO push colliding with the end-of-frame pop.
    task automatic test_fill_stall;
        logic [7:0] b [10];
        int         idx;
        bit         exp_stall, to;
        b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h5A, 8'hC3};
        rx_q.delete(); frame_err = 0;
        idx = 0;
        for (int k = 0; k <= 42; k++) begin
            @(negedge clk);
            if (k == 9) begin
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL t3_count_full: got %0d want 8", count); end
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL t3_full_flag: got %b want 1", full); end
            end
            if (k == 42) begin
                checks++; if (count !== 4'd7) begin errors++; $display("FAIL t4_count_after_collision: got %0d want 7", count); end
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL t4_full_after_collision: got %b want 0", full); end
            end
            valid = 1'b1; data = b[idx];
            #1;
            exp_stall = (k >= 9 && k <= 41);
            checks++; if (stall !== exp_stall) begin errors++; $display("FAIL t3_stall_k%0d: got %b want %b", k, stall, exp_stall); end
            if (!exp_stall) idx++;
        end
        @(negedge clk);
        valid = 1'b0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL t4_count_refill: got %0d want 8", count); end
        wait_idle(600, to);
        checks++; if (to) begin errors++; $display("FAIL t3_idle_timeout: got timeout want idle"); end
        checks++; if (rx_q.size() != 10) begin errors++; $display("FAIL t3_rx_size: got %0d want 10", rx_q.size()); end
        else begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (rx_q[i] !== b[i]) begin errors++; $display("FAIL t3_rx_%0d: got %h want %h", i, rx_q[i], b[i]); end
            end
        end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL t3_framing: got %0d want 0", frame_err); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b [5];
        int         tx_low, busy_hi;
        b = '{8'h96, 8'h11, 8'h22, 8'h33, 8'h44};
        rx_q.delete(); frame_err = 0;
        @(negedge clk);
        valid = 1'b1; data = b[0];
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            data = b[i];
        end
        @(negedge clk);
        valid = 1'b0;
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL t5_queued: got %0d want 4", count); end
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_before_rst: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL t5_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b want 0", busy); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL t5_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t5_empty: got %b want 1", empty); end
        @(negedge clk);
        rst = 1'b0;
        tx_low = 0; busy_hi = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
        end
        checks++; if (tx_low != 0) begin errors++; $display("FAIL t5_quiet_tx: got %0d low cycles want 0", tx_low); end
        checks++; if (busy_hi != 0) begin errors++; $display("FAIL t5_quiet_busy: got %0d busy cycles want 0", busy_hi); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL t5_no_frames: got %0d want 0", rx_q.size()); end
    endtask

    task automatic test_wrap;
        logic [7:0] b [16];
        int         n;
        bit         to;
        for (int i = 0; i < 16; i++) b[i] = 8'h40 + 8'(i * 7);
        rx_q.delete(); frame_err = 0;
        to = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16 && !to; i++) begin
            valid = 1'b1; data = b[i];
            #1;
            n = 0;
            while (stall) begin
                @(negedge clk);
                #1;
                n++;
                if (n > 200) begin
                    to = 1'b1;
                    break;
                end
            end
            @(negedge clk);
        end
        valid = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL t6_push_timeout: got stuck stall want accept"); end
        wait_idle(900, to);
        checks++; if (to) begin errors++; $display("FAIL t6_idle_timeout: got timeout want idle"); end
        checks++; if (rx_q.size() != 16) begin errors++; $display("FAIL t6_rx_size: got %0d want 16", rx_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (rx_q[i] !== b[i]) begin errors++; $display("FAIL t6_rx_%0d: got %h want %h", i, rx_q[i], b[i]); end
            end
        end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL t6_framing: got %0d want 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fill_stall();
        test_reset_mid_frame();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
